sbox_check: RTL and testbench
=============================

// Module: sbox_check
// PURPOSE
//  Reader-side counterpart of the S-array initialiser. Sweeps the S memory
//  (addr 0..N-1), reads each entry and checks it: either S[i]==i (identity,
//  i.e. post-init) or that S holds a permutation (post-KSA, no duplicates).
//  Sits beside init/ksa on the s_mem port; used by the top FSM and benches
//  for self-check. Uses the same en/rdy handshake as the other ARC4 stages.
// PARAMETERS
//  N            256  number of S entries swept (addr 0..N-1)
//  W            8    data and address width; N <= 2**W
//  CHECK_IDENT  1    1: require S[i]==i; 0: require permutation (no dup value)
// PORTS
//  clk        in   1   clock, all state changes on posedge
//  rst        in   1   asynchronous, active-high reset
//  en         in   1   start request, honoured only when rdy==1
//  rdy        out  1   1 = idle and able to accept en
//  addr       out  W   S memory read address
//  rden       out  1   1 while addr carries a valid read address
//  rddata     in   W   S memory read data; valid exactly 1 cycle after addr
//  done       out  1   one-cycle pulse when the result is valid
//  pass       out  1   1 = all N entries passed; held until next start
//  err_count  out  W+1 number of failing entries (0..N); held
//  fail_addr  out  W   index of first failing entry; 0 if pass; held
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rdy=1, addr=0, rden=0, done=0,
//   pass=0, err_count=0, fail_addr=0, seen bitmap cleared.
//  States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  IDLE: rdy=1. Posedge with en=1: clear err_count/fail_addr/pass/seen,
//   go READ. Call this edge T. en while rdy=0 ignored; en held high starts
//   a new run only on the next IDLE cycle.
//  READ: rdy=0, rden=1, addr=0 in cycle after T, +1 each cycle up to N-1
//   (cycles T+1..T+N). After addr N-1 -> DRAIN (rden=0, addr holds N-1).
//  Check pipeline: addr registered into idx_q; rddata checked the cycle
//   after its addr (indices 0..N-1 checked in cycles T+2..T+N+1).
//   IDENT: fail if rddata != idx_q. PERM: fail if seen[rddata]==1; then set
//   seen[rddata]. A fail increments err_count; first fail loads fail_addr.
//  DRAIN: one cycle, checks index N-1, -> DONE.
//  DONE (cycle T+N+2): done=1, pass = (err_count==0) including last check;
//   next cycle IDLE with rdy=1. Total: rdy low for N+2 cycles.
//  In PERM mode, N entries with no duplicate == permutation (pigeonhole);
//   rddata >= N counts as a fail. err_count never wraps (max N fits W+1).
//  addr never exceeds N-1; no write port -- block never modifies memory.
//  Reset mid-run aborts immediately; outputs return to reset values; no done.
// TESTING
//  1 Reset, S[i]=i, pulse en at T, IDENT -> addr 0..255 on T+1..T+256,
//    done at T+258, pass=1, err_count=0, fail_addr=0, rdy=1 at T+259.
//  2 IDENT, S[5]=7, rest identity -> pass=0, err_count=1, fail_addr=5.
//  3 PERM, identity with S[3]<->S[200] swapped -> pass=1, err_count=0.
//  4 PERM, identity but S[20]=10 -> pass=0, err_count=1, fail_addr=20;
//    then all S[i]=0 -> err_count=255, fail_addr=1.
//  5 en held high 600 cycles -> runs back-to-back, each done spaced 259
//    cycles, en during busy never restarts sweep.
//  6 rst asserted while addr==100 -> same cycle rdy=1, rden=0, addr=0,
//    pass=0; no done; fresh en then completes normally with pass=1.

Source files
------------

// File: rtl/sbox_check.sv
// Sweeps the S memory once per start and checks it is either the identity
// or a permutation; reports pass, error count and first failing index.
module sbox_check #(
    parameter int N           = 256,
    parameter int W           = 8,
    parameter int CHECK_IDENT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         rdy,
    output logic [W-1:0] addr,
    output logic         rden,
    input  logic [W-1:0] rddata,
    output logic         done,
    output logic         pass,
    output logic [W:0]   err_count,
    output logic [W-1:0] fail_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [W-1:0] LAST_ADDR = W'(N - 1);

    state_t            state;
    logic [W-1:0]      idx_q;
    logic              chk_v;
    logic [2**W-1:0]   seen;
    logic              fail;
    logic [W:0]        err_next;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        fail = 1'b0;
        if (chk_v) begin
            if (CHECK_IDENT != 0)
                fail = (rddata != idx_q);
            else
                fail = (int'(rddata) >= N) || seen[rddata];
        end
        err_next = err_count + {{W{1'b0}}, fail};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the values from before this clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rdy       <= 1'b1;
            addr      <= '0;
            rden      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            idx_q     <= '0;
            chk_v     <= 1'b0;
            // NOTE: the seen bitmap is a flop array, not a RAM, so it can and
            // must be cleared by reset to avoid stale bits leaking into a run.
            seen      <= '0;
        end else begin
            idx_q <= addr;
            chk_v <= rden;
            done  <= 1'b0;

            // Check stage runs one cycle behind the read address.
            if (chk_v) begin
                err_count <= err_next;
                if (fail && err_count == '0)
                    fail_addr <= idx_q;
                if (CHECK_IDENT == 0 && int'(rddata) < N)
                    seen[rddata] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (en) begin
                        state     <= S_READ;
                        rdy       <= 1'b0;
                        rden      <= 1'b1;
                        addr      <= '0;
                        err_count <= '0;
                        fail_addr <= '0;
                        pass      <= 1'b0;
                        seen      <= '0;
                    end
                end
                S_READ: begin
                    if (addr == LAST_ADDR) begin
                        state <= S_DRAIN;
                        rden  <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Last index is checked this cycle, so pass uses err_next.
                    state <= S_DONE;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    rdy   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b1;
                    rden  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_check.sv
// Scoreboard bench for sbox_check: one identity-mode and one permutation-mode
// instance read a shared S memory; results are compared against a loop model.
module tb_sbox_check;

    localparam int N = 256;
    localparam int W = 8;

    typedef struct {
        bit pass;
        int ec;
        int fa;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en_w      [2];
    logic         rdy_w     [2];
    logic [W-1:0] addr_w    [2];
    logic         rden_w    [2];
    logic [W-1:0] rd_w      [2];
    logic         done_w    [2];
    logic         pass_w    [2];
    logic [W:0]   err_w     [2];
    logic [W-1:0] fa_w      [2];

    logic [W-1:0] mem [N];
    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_w[0] <= mem[addr_w[0]];
        rd_w[1] <= mem[addr_w[1]];
    end

    sbox_check #(.N(N), .W(W), .CHECK_IDENT(1)) u_ident (
        .clk(clk), .rst(rst), .en(en_w[0]), .rdy(rdy_w[0]), .addr(addr_w[0]),
        .rden(rden_w[0]), .rddata(rd_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_addr(fa_w[0])
    );

    sbox_check #(.N(N), .W(W), .CHECK_IDENT(0)) u_perm (
        .clk(clk), .rst(rst), .en(en_w[1]), .rdy(rdy_w[1]), .addr(addr_w[1]),
        .rden(rden_w[1]), .rddata(rd_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_addr(fa_w[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: identity mode flags S[i]!=i; permutation mode flags any value
    // out of range or equal to a value stored at an earlier index.
    function automatic exp_t model(input bit ident);
        exp_t e;
        bit   f;
        e.ec = 0;
        e.fa = 0;
        for (int i = 0; i < N; i++) begin
            if (ident) begin
                f = (int'(mem[i]) != i);
            end else begin
                f = (int'(mem[i]) >= N);
                for (int j = 0; j < i; j++)
                    if (mem[j] == mem[i]) f = 1'b1;
            end
            if (f) begin
                if (e.ec == 0) e.fa = i;
                e.ec++;
            end
        end
        e.pass = (e.ec == 0);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic compare_result(input int k, input exp_t e);
        string tag;
        tag = (k == 0) ? "ident" : "perm";
        check({tag, "_pass"},      32'(pass_w[k]), 32'(e.pass));
        check({tag, "_err_count"}, 32'(err_w[k]),  e.ec);
        check({tag, "_fail_addr"}, 32'(fa_w[k]),   e.fa);
        check({tag, "_done_cycle"}, cyc,           e.cyc);
        check({tag, "_rdy_at_done"}, 32'(rdy_w[k]), 0);
    endtask

    // Monitor: every done pulse pops the oldest expectation for that instance.
    always @(negedge clk) begin
        exp_t e;
        if (done_w[0]) begin
            if (sb0.size() == 0) check("ident_unexpected_done", 32'(done_w[0]), 0);
            else begin
                e = sb0.pop_front();
                compare_result(0, e);
            end
        end
        if (done_w[1]) begin
            if (sb1.size() == 0) check("perm_unexpected_done", 32'(done_w[1]), 0);
            else begin
                e = sb1.pop_front();
                compare_result(1, e);
            end
        end
    end

    task automatic set_identity();
        for (int i = 0; i < N; i++) mem[i] = W'(i);
    endtask

    task automatic start(input bit [1:0] mask, input bit expect_done);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (mask[k]) begin
                e     = model(k == 0);
                e.cyc = cyc + N + 2;
                if (expect_done) begin
                    if (k == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                end
                en_w[k] = 1'b1;
            end
        end
        @(negedge clk);
        en_w[0] = 1'b0;
        en_w[1] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (sb0.size() != 0 || sb1.size() != 0); i++)
            @(negedge clk);
        check("scoreboard_drain_timeout", sb0.size() + sb1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   seq_bad;
        int   j;
        exp_t e;
        logic [W-1:0] tmp;

        en_w[0] = 1'b0;
        en_w[1] = 1'b0;
        set_identity();
        repeat (3) @(negedge clk);
        check("reset_rdy",       32'(rdy_w[0]),  1);
        check("reset_addr",      32'(addr_w[0]), 0);
        check("reset_rden",      32'(rden_w[0]), 0);
        check("reset_done",      32'(done_w[0]), 0);
        check("reset_pass",      32'(pass_w[0]), 0);
        check("reset_err_count", 32'(err_w[0]),  0);
        check("reset_fail_addr", 32'(fa_w[0]),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Identity memory, both modes; also trace the address sweep.
        start(2'b11, 1'b1);
        seq_bad = 0;
        for (int i = 0; i < N; i++) begin
            if (!(rden_w[0] && int'(addr_w[0]) == i && !rdy_w[0])) seq_bad++;
            @(negedge clk);
        end
        check("addr_sequence",   seq_bad, 0);
        check("drain_rden",      32'(rden_w[0]), 0);
        check("drain_addr_hold", 32'(addr_w[0]), N - 1);
        @(negedge clk);
        check("rdy_low_at_done", 32'(rdy_w[0]), 0);
        @(negedge clk);
        check("rdy_back_after_done", 32'(rdy_w[0]), 1);
        wait_idle();

        // Single corrupted entry.
        set_identity();
        mem[5] = 8'd7;
        start(2'b11, 1'b1);
        wait_idle();

        // Swap keeps a valid permutation.
        set_identity();
        mem[3]   = 8'd200;
        mem[200] = 8'd3;
        start(2'b11, 1'b1);
        wait_idle();

        // Duplicate value, then all-zero memory.
        set_identity();
        mem[20] = 8'd10;
        start(2'b11, 1'b1);
        wait_idle();
        for (int i = 0; i < N; i++) mem[i] = '0;
        start(2'b11, 1'b1);
        wait_idle();

        // Random permutations, some with planted corruptions.
        for (int r = 0; r < 4; r++) begin
            set_identity();
            for (int i = N - 1; i > 0; i--) begin
                j      = $urandom_range(i, 0);
                tmp    = mem[i];
                mem[i] = mem[j];
                mem[j] = tmp;
            end
            if (r % 2 == 1) begin
                for (int m = 0; m < 1 + r / 2; m++)
                    mem[$urandom_range(N - 1, 0)] = W'($urandom_range(N - 1, 0));
            end
            start(2'b11, 1'b1);
            wait_idle();
        end

        // en held high: back-to-back runs every N+3 cycles, never restarted early.
        set_identity();
        mem[77] = 8'd1;
        @(negedge clk);
        e = model(1'b1);
        for (int k = 0; k < 3; k++) begin
            e.cyc = cyc + N + 2 + k * (N + 3);
            sb0.push_back(e);
        end
        en_w[0] = 1'b1;
        repeat (600) @(negedge clk);
        en_w[0] = 1'b0;
        wait_idle();

        // Reset mid-sweep aborts without a done pulse.
        set_identity();
        start(2'b01, 1'b0);
        for (int i = 0; i < 300 && addr_w[0] != 8'd100; i++) @(negedge clk);
        check("reached_addr_100", 32'(addr_w[0]), 100);
        rst = 1'b1;
        #1;
        check("abort_rdy",  32'(rdy_w[0]),  1);
        check("abort_rden", 32'(rden_w[0]), 0);
        check("abort_addr", 32'(addr_w[0]), 0);
        check("abort_pass", 32'(pass_w[0]), 0);
        check("abort_err_count", 32'(err_w[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 10) @(negedge clk);
        start(2'b01, 1'b1);
        wait_idle();
        check("final_pass_held", 32'(pass_w[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
